// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin share of one OBI secondary port with in-order response routing.
// Define OBI_RR_ARBITER_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module obi_rr_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_PORTS-1:0]    m_req_i,
  output logic [NUM_PORTS-1:0]    m_gnt_o,
  input  logic [32*NUM_PORTS-1:0] m_addr_i,
  input  logic [NUM_PORTS-1:0]    m_we_i,
  input  logic [4*NUM_PORTS-1:0]  m_be_i,
  input  logic [32*NUM_PORTS-1:0] m_wdata_i,
  output logic [NUM_PORTS-1:0]    m_rvalid_o,
  output logic [31:0]             m_rdata_o,
  output logic                    s_req_o,
  input  logic                    s_gnt_i,
  output logic [31:0]             s_addr_o,
  output logic                    s_we_o,
  output logic [3:0]              s_be_o,
  output logic [31:0]             s_wdata_o,
  input  logic                    s_rvalid_i,
  input  logic [31:0]             s_rdata_i
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int AW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic {ARB, HOLD} state_e;
  state_e        state_q;
  logic [IW-1:0] hold_id_q, win, sel, head_id, start;
  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          full, empty, accept, pop;
`ifdef OBI_RR_ARBITER_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IW-1:0] rr_ptr_q;
  assign start = rr_ptr_q;
`endif
  always_comb begin
    win = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (m_req_i[(int'(start) + i) % NUM_PORTS]) win = IW'((int'(start) + i) % NUM_PORTS);
    end
  end
  assign full    = count_q == CW'(MAX_OUTSTANDING);
  assign empty   = count_q == '0;
  assign sel     = state_q == HOLD ? hold_id_q : win;
  // A held request follows its owner so a dropped request can never be accepted.
  assign s_req_o = state_q == HOLD ? m_req_i[hold_id_q] : (|m_req_i) && !full;
  assign accept  = s_req_o && s_gnt_i;
  assign m_gnt_o = accept ? NUM_PORTS'(1) << sel : '0;
  assign s_addr_o  = m_addr_i[32*sel +: 32];
  assign s_we_o    = m_we_i[sel];
  assign s_be_o    = m_be_i[4*sel +: 4];
  assign s_wdata_o = m_wdata_i[32*sel +: 32];
  assign head_id    = fifo_q[head_q];
  assign pop        = s_rvalid_i && !empty;
  assign m_rvalid_o = pop ? NUM_PORTS'(1) << head_id : '0;
  assign m_rdata_o  = s_rdata_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB;
      hold_id_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
`ifndef OBI_RR_ARBITER_FIXED_PRIO_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      state_q <= s_req_o && !s_gnt_i ? HOLD : ARB;
      if (state_q == ARB) hold_id_q <= win;
      if (accept) begin
        fifo_q[tail_q] <= sel;
        tail_q <= tail_q == AW'(MAX_OUTSTANDING - 1) ? '0 : tail_q + 1'b1;
`ifndef OBI_RR_ARBITER_FIXED_PRIO_EN
        rr_ptr_q <= sel == IW'(NUM_PORTS - 1) ? '0 : sel + 1'b1;
`endif
      end
      if (pop) head_q <= head_q == AW'(MAX_OUTSTANDING - 1) ? '0 : head_q + 1'b1;
      count_q <= count_q + CW'(accept) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb_obi_rr_arbiter: directed checks of grant order, HOLD stability, full masking and reset.
module tb_obi_rr_arbiter;
`ifdef OBI_RR_ARBITER_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req, m_gnt, m_we, m_rvalid;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_be;
  logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
  logic        s_req, s_gnt, s_we, s_rvalid;
  logic [3:0]  s_be;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  obi_rr_arbiter #(.NUM_PORTS(2), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst), .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr),
    .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid),
    .m_rdata_o(m_rdata), .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr),
    .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid),
    .s_rdata_i(s_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    m_addr = {32'h2000, 32'h1000}; m_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    m_we = 2'b10; m_be = 8'h3F;
    tick; tick;
    rst = 1'b0; #1;
    chk("rst_sreq", 32'(s_req), 0);
    chk("rst_gnt", 32'(m_gnt), 0);
    chk("rst_rvalid", 32'(m_rvalid), 0);
    chk("rst_count", 32'(dut.count_q), 0);
    chk("idle_addr_port0", s_addr, 32'h1000);
    tick;
    // alternating grants with a response one cycle after each accept
    for (int n = 0; n < 5; n++) begin
      m_req = n < 4 ? 2'b11 : 2'b00; s_gnt = 1'b1;
      s_rvalid = n > 0; s_rdata = 32'hA5A5_0000 + 32'(n - 1);
      #1;
      chk($sformatf("rr_gnt%0d", n), 32'(m_gnt), n < 4 ? (FIXED || n % 2 == 0 ? 1 : 2) : 0);
      if (n > 0) begin
        chk($sformatf("rr_rvalid%0d", n), 32'(m_rvalid), FIXED || (n - 1) % 2 == 0 ? 1 : 2);
        chk($sformatf("rr_rdata%0d", n), m_rdata, 32'hA5A5_0000 + 32'(n - 1));
      end
      if (n < 4) chk($sformatf("rr_addr%0d", n), s_addr, FIXED || n % 2 == 0 ? 32'h1000 : 32'h2000);
      tick;
    end
    s_rvalid = 1'b0;
    // HOLD: port0 stalled three cycles, port1 arrives meanwhile
    for (int n = 0; n < 5; n++) begin
      m_req = n == 0 ? 2'b01 : n < 4 ? 2'b11 : 2'b10;
      s_gnt = n >= 3;
      #1;
      chk($sformatf("hold_addr%0d", n), s_addr, n < 4 ? 32'h1000 : 32'h2000);
      chk($sformatf("hold_gnt%0d", n), 32'(m_gnt), n < 3 ? 0 : n == 3 ? 1 : 2);
      chk($sformatf("hold_sreq%0d", n), 32'(s_req), 1);
      tick;
    end
    m_req = 2'b00; s_gnt = 1'b0;
    for (int n = 0; n < 2; n++) begin
      s_rvalid = 1'b1; s_rdata = 32'(n); #1;
      chk($sformatf("hold_rvalid%0d", n), 32'(m_rvalid), n == 0 ? 1 : 2);
      tick;
    end
    s_rvalid = 1'b0;
    // full masking: two accepts then s_req drops until the cycle after a pop
    m_req = 2'b11; s_gnt = 1'b1; #1;
    chk("full_gnt0", 32'(m_gnt), 1);
    tick; #1;
    chk("full_gnt1", 32'(m_gnt), FIXED ? 1 : 2);
    tick; #1;
    chk("full_sreq", 32'(s_req), 0);
    chk("full_nogrant", 32'(m_gnt), 0);
    tick;
    s_rvalid = 1'b1; #1;
    chk("pop_rvalid", 32'(m_rvalid), 1);
    chk("pop_same_cycle_sreq", 32'(s_req), 0);
    tick;
    s_rvalid = 1'b0; #1;
    chk("pop_next_sreq", 32'(s_req), 1);
    chk("pop_next_gnt", 32'(m_gnt), 1);
    tick;
    m_req = 2'b00; s_gnt = 1'b0; #1;
    chk("pre_rst_count", 32'(dut.count_q), 2);
    // reset with two outstanding, then stale responses are dropped
    rst = 1'b1;
    tick;
    rst = 1'b0; #1;
    chk("midrst_sreq", 32'(s_req), 0);
    chk("midrst_count", 32'(dut.count_q), 0);
    s_rvalid = 1'b1; #1;
    chk("stale_rvalid", 32'(m_rvalid), 0);
    tick;
    s_rvalid = 1'b0; #1;
    chk("stale_count", 32'(dut.count_q), 0);
    m_req = 2'b11; s_gnt = 1'b1; #1;
    chk("post_rst_gnt", 32'(m_gnt), 1);
    tick;
    m_req = 2'b00; s_gnt = 1'b0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
